// File: rtl/ysyx_22040895_trap_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ysyx_22040895_trap_ctrl_if: execute/CSR-file/fetch bundle of the trap sequencer
// Revision: 1.0
// ============================================================================
interface ysyx_22040895_trap_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 3
);
  logic              trap_valid;
  logic              trap_ready;
  logic              trap_mret;
  logic [XLEN-1:0]   trap_pc;
  logic [XLEN-1:0]   trap_cause;
  logic              csr_req_we;
  logic [CSR_AW-1:0] csr_req_waddr;
  logic [XLEN-1:0]   csr_req_wdata;
  logic              csr_req_ready;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              mepc_set;
  logic [XLEN-1:0]   mepc_wdata;
  logic              mepc_get;
  logic [XLEN-1:0]   mepc_rdata;
  logic              mcause_set;
  logic [XLEN-1:0]   mcause_wdata;
  logic              mtvec_get;
  logic [XLEN-1:0]   mtvec_rdata;
  logic              mstatus_set;
  logic [XLEN-1:0]   mstatus_wdata;
  logic              mstatus_get;
  logic [XLEN-1:0]   mstatus_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              busy;

  modport slave (
    input  trap_valid, trap_mret, trap_pc, trap_cause,
    input  csr_req_we, csr_req_waddr, csr_req_wdata,
    input  mepc_rdata, mtvec_rdata, mstatus_rdata,
    output trap_ready, csr_req_ready, csr_we, csr_waddr, csr_wdata,
    output mepc_set, mepc_wdata, mepc_get, mcause_set, mcause_wdata,
    output mtvec_get, mstatus_set, mstatus_wdata, mstatus_get,
    output redirect_valid, redirect_pc, busy
  );

  modport master (
    output trap_valid, trap_mret, trap_pc, trap_cause,
    output csr_req_we, csr_req_waddr, csr_req_wdata,
    output mepc_rdata, mtvec_rdata, mstatus_rdata,
    input  trap_ready, csr_req_ready, csr_we, csr_waddr, csr_wdata,
    input  mepc_set, mepc_wdata, mepc_get, mcause_set, mcause_wdata,
    input  mtvec_get, mstatus_set, mstatus_wdata, mstatus_get,
    input  redirect_valid, redirect_pc, busy
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040895_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ysyx_22040895_trap_ctrl: M-mode ecall/mret sequencer and CSR write-port arbiter
// Revision: 1.0
// ============================================================================
module ysyx_22040895_trap_ctrl #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 3
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  ysyx_22040895_trap_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_T_SAVE   = 3'd1,
    S_T_STATUS = 3'd2,
    S_T_JUMP   = 3'd3,
    S_R_STATUS = 3'd4,
    S_R_JUMP   = 3'd5
  } state_e;

  localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    cause_d            = cause_q;
    bus.trap_ready     = 1'b0;
    bus.csr_req_ready  = 1'b0;
    bus.csr_we         = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.mepc_set       = 1'b0;
    bus.mepc_wdata     = '0;
    bus.mepc_get       = 1'b0;
    bus.mcause_set     = 1'b0;
    bus.mcause_wdata   = '0;
    bus.mtvec_get      = 1'b0;
    bus.mstatus_set    = 1'b0;
    bus.mstatus_wdata  = '0;
    bus.mstatus_get    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.busy           = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // A pending trap wins over a CSR-instruction write; the write is held off.
        bus.trap_ready    = 1'b1;
        bus.csr_req_ready = ~bus.trap_valid;
        bus.csr_we        = bus.csr_req_we & ~bus.trap_valid;
        bus.csr_waddr     = CSR_AW'(bus.csr_req_waddr);
        bus.csr_wdata     = bus.csr_req_wdata;
        if (bus.trap_valid) begin
          pc_d    = bus.trap_pc;
          cause_d = bus.trap_cause;
          state_d = bus.trap_mret ? S_R_STATUS : S_T_SAVE;
        end
      end
      S_T_SAVE: begin
        bus.mepc_set     = 1'b1;
        bus.mepc_wdata   = pc_q & c_align_mask;
        bus.mcause_set   = 1'b1;
        bus.mcause_wdata = cause_q;
        state_d          = S_T_STATUS;
      end
      S_T_STATUS: begin
        bus.mstatus_get       = 1'b1;
        bus.mstatus_set       = 1'b1;
        bus.mstatus_wdata     = bus.mstatus_rdata;
        bus.mstatus_wdata[7]  = bus.mstatus_rdata[3];
        bus.mstatus_wdata[3]  = 1'b0;
        bus.mstatus_wdata[12:11] = 2'b11;
        state_d               = S_T_JUMP;
      end
      S_T_JUMP: begin
        bus.mtvec_get      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.mtvec_rdata & c_align_mask;
        state_d            = S_IDLE;
      end
      S_R_STATUS: begin
        bus.mstatus_get       = 1'b1;
        bus.mstatus_set       = 1'b1;
        bus.mstatus_wdata     = bus.mstatus_rdata;
        bus.mstatus_wdata[3]  = bus.mstatus_rdata[7];
        bus.mstatus_wdata[7]  = 1'b1;
        bus.mstatus_wdata[12:11] = 2'b11;
        state_d               = S_R_JUMP;
      end
      S_R_JUMP: begin
        bus.mepc_get       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.mepc_rdata;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The reset cycle must not leak a write or redirect from an aborted sequence.
    if (rst) begin
      bus.csr_we         = 1'b0;
      bus.mepc_set       = 1'b0;
      bus.mepc_get       = 1'b0;
      bus.mcause_set     = 1'b0;
      bus.mtvec_get      = 1'b0;
      bus.mstatus_set    = 1'b0;
      bus.mstatus_get    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ysyx_22040895_trap_ctrl: directed scoreboard bench for the trap sequencer
// Revision: 1.0
// ============================================================================
module tb_ysyx_22040895_trap_ctrl;

  typedef struct packed {
    logic        mepc_set;
    logic [63:0] mepc;
    logic        mcause_set;
    logic [63:0] mcause;
    logic        mstatus_set;
    logic [63:0] mstatus;
    logic        redir;
    logic [63:0] rpc;
    logic        we;
    logic [2:0]  waddr;
    logic [63:0] wdata;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  ysyx_22040895_trap_ctrl_if #(.XLEN(64), .CSR_AW(3)) bus ();

  ysyx_22040895_trap_ctrl #(.XLEN(64), .CSR_AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic ev_t ev_save(input logic [63:0] pc, input logic [63:0] cause);
    ev_t e = '0;
    e.mepc_set = 1'b1; e.mepc = pc; e.mcause_set = 1'b1; e.mcause = cause;
    return e;
  endfunction

  function automatic ev_t ev_status(input logic [63:0] v);
    ev_t e = '0;
    e.mstatus_set = 1'b1; e.mstatus = v;
    return e;
  endfunction

  function automatic ev_t ev_redir(input logic [63:0] pc);
    ev_t e = '0;
    e.redir = 1'b1; e.rpc = pc;
    return e;
  endfunction

  function automatic ev_t ev_wr(input logic [2:0] a, input logic [63:0] d);
    ev_t e = '0;
    e.we = 1'b1; e.waddr = a; e.wdata = d;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Issue one request: drive after a rising edge, release right after the accepting edge.
  task automatic issue(input logic mret, input logic [63:0] pc, input logic [63:0] cause);
    @(posedge clk); #1;
    bus.trap_valid = 1'b1; bus.trap_mret = mret; bus.trap_pc = pc; bus.trap_cause = cause;
    @(posedge clk); #1;
    bus.trap_valid = 1'b0;
  endtask

  // Monitor: every cycle carrying a CSR write or redirect pops one expected event.
  always @(negedge clk) begin
    ev_t o;
    ev_t e;
    if (mon_en) begin
      o = '0;
      if (bus.mepc_set === 1'b1)       begin o.mepc_set = 1'b1;    o.mepc = bus.mepc_wdata; end
      if (bus.mcause_set === 1'b1)     begin o.mcause_set = 1'b1;  o.mcause = bus.mcause_wdata; end
      if (bus.mstatus_set === 1'b1)    begin o.mstatus_set = 1'b1; o.mstatus = bus.mstatus_wdata; end
      if (bus.redirect_valid === 1'b1) begin o.redir = 1'b1;       o.rpc = bus.redirect_pc; end
      if (bus.csr_we === 1'b1)         begin o.we = 1'b1; o.waddr = bus.csr_waddr; o.wdata = bus.csr_wdata; end
      if (o.mepc_set | o.mcause_set | o.mstatus_set | o.redir | o.we) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected @%0t: got %h want none", $time, o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_fail++;
            $display("FAIL sb_event @%0t: got %h want %h", $time, o, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  wait_i;
    logic got_ready;
    bus.trap_valid = 1'b0; bus.trap_mret = 1'b0; bus.trap_pc = '0; bus.trap_cause = '0;
    bus.csr_req_we = 1'b0; bus.csr_req_waddr = '0; bus.csr_req_wdata = '0;
    bus.mepc_rdata = '0; bus.mtvec_rdata = '0; bus.mstatus_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_trap_ready", 64'(bus.trap_ready), 64'd1);
    check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    check("rst_redirect_pc", bus.redirect_pc, 64'd0);

    // ecall entry
    bus.mtvec_rdata = 64'h8000_0200; bus.mstatus_rdata = 64'h8;
    exp_q.push_back(ev_save(64'h8000_0104, 64'd11));
    exp_q.push_back(ev_status(64'h1880));
    exp_q.push_back(ev_redir(64'h8000_0200));
    issue(1'b0, 64'h8000_0104, 64'd11);
    @(negedge clk);
    check("ecall_busy_c1", 64'(bus.busy), 64'd1);
    check("ecall_ready_c1", 64'(bus.trap_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("ecall_ready_c4", 64'(bus.trap_ready), 64'd1);

    // mret
    bus.mepc_rdata = 64'h8000_0108; bus.mstatus_rdata = 64'h1880;
    exp_q.push_back(ev_status(64'h1888));
    exp_q.push_back(ev_redir(64'h8000_0108));
    issue(1'b1, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    check("mret_busy_c3", 64'(bus.busy), 64'd0);
    check("mret_ready_c3", 64'(bus.trap_ready), 64'd1);

    // trap and CSR write together: trap first, write lands once afterwards
    bus.mstatus_rdata = 64'h8;
    exp_q.push_back(ev_save(64'h8000_0110, 64'd11));
    exp_q.push_back(ev_status(64'h1880));
    exp_q.push_back(ev_redir(64'h8000_0200));
    exp_q.push_back(ev_wr(3'd2, 64'h8000_0300));
    @(posedge clk); #1;
    bus.trap_valid = 1'b1; bus.trap_mret = 1'b0; bus.trap_pc = 64'h8000_0110; bus.trap_cause = 64'd11;
    bus.csr_req_we = 1'b1; bus.csr_req_waddr = 3'd2; bus.csr_req_wdata = 64'h8000_0300;
    @(negedge clk);
    check("prio_csr_we", 64'(bus.csr_we), 64'd0);
    check("prio_csr_req_ready", 64'(bus.csr_req_ready), 64'd0);
    @(posedge clk); #1;
    bus.trap_valid = 1'b0;
    got_ready = 1'b0;
    wait_i = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.csr_req_ready === 1'b1) begin
        got_ready = 1'b1;
        wait_i = i;
        break;
      end
    end
    check("prio_csr_ready_seen", 64'(got_ready), 64'd1);
    check("prio_csr_ready_cycle", 64'(wait_i), 64'd3);
    @(posedge clk); #1;
    bus.csr_req_we = 1'b0;

    // trap_valid during T_STATUS is ignored until trap_ready returns
    exp_q.push_back(ev_save(64'h8000_0120, 64'd11));
    exp_q.push_back(ev_status(64'h1880));
    exp_q.push_back(ev_redir(64'h8000_0200));
    exp_q.push_back(ev_save(64'h8000_0140, 64'd8));
    exp_q.push_back(ev_status(64'h1880));
    exp_q.push_back(ev_redir(64'h8000_0200));
    issue(1'b0, 64'h8000_0120, 64'd11);
    @(posedge clk); #1;
    bus.trap_valid = 1'b1; bus.trap_pc = 64'h8000_0140; bus.trap_cause = 64'd8;
    @(negedge clk);
    check("b2b_ready_c2", 64'(bus.trap_ready), 64'd0);
    @(negedge clk);
    check("b2b_ready_c3", 64'(bus.trap_ready), 64'd0);
    @(negedge clk);
    check("b2b_ready_c4", 64'(bus.trap_ready), 64'd1);
    @(posedge clk); #1;
    bus.trap_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_second_done", 64'(bus.busy), 64'd0);

    // reset during T_STATUS aborts the sequence
    exp_q.push_back(ev_save(64'h8000_0130, 64'd11));
    issue(1'b0, 64'h8000_0130, 64'd11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_mstatus_set", 64'(bus.mstatus_set), 64'd0);
    check("abort_redirect", 64'(bus.redirect_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_trap_ready", 64'(bus.trap_ready), 64'd1);
    check("abort_redirect_pc", bus.redirect_pc, 64'd0);
    check("abort_gets", {61'd0, bus.mtvec_get, bus.mepc_get, bus.mstatus_get}, 64'd0);

    // misaligned mtvec and trap_pc are forced to word alignment
    bus.mtvec_rdata = 64'h8000_0203; bus.mstatus_rdata = 64'h0;
    exp_q.push_back(ev_save(64'h8000_0104, 64'd11));
    exp_q.push_back(ev_status(64'h1800));
    exp_q.push_back(ev_redir(64'h8000_0200));
    issue(1'b0, 64'h8000_0106, 64'd11);
    repeat (4) @(negedge clk);
    check("align_done", 64'(bus.busy), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
